hello_rx_checker: RTL
=====================

// Module: hello_rx_checker
// PURPOSE
//  Receive end of the HELLO letter-code stream. Consumes one 3-bit letter code per InValid strobe.
//  Detects the complete word H-E-L-L-O, counts matched words and flags protocol errors.
//  Drives a registered active-low 7-seg image of the last accepted letter.
//  Sits between the letter generator (or a link from it) and the display/status logic.
// PARAMETERS
//  CNT_W    8   width of WordCount (saturating)
//  TIMEOUT  16  max cycles allowed between symbols mid-word (>=2)
// PORTS
//  Clock      in   1      clock, all logic on posedge
//  Reset      in   1      synchronous, active-low
//  In         in   3      letter code: Blank=000 H=001 E=010 L=011 O=100; 101..111 illegal
//  InValid    in   1      In carries a symbol this cycle (one symbol per high cycle)
//  Match      out  1      1-cycle pulse: HELLO completed
//  Error      out  1      1-cycle pulse: mismatch, illegal code or timeout
//  WordCount  out  CNT_W  matched words, saturates at all-ones
//  Progress   out  3      letters of current word matched so far (0..4)
//  LastSeg    out  7      active-low gfedcba image of last accepted symbol
// BEHAVIOUR
//  - Reset (Reset==0 at posedge): state IDLE, Match=0, Error=0, WordCount=0, Progress=0,
//    LastSeg=7'b1111111, timer=0. Applies mid-word; partial word is discarded, no Error pulse.
//  - All outputs registered; response appears the cycle after the posedge sampling InValid=1.
//  - FSM: IDLE -> GOT_H -> GOT_E -> GOT_L1 -> GOT_L2; Progress = 0,1,2,3,4 respectively.
//    IDLE: H -> GOT_H; Blank -> stay IDLE, no error; E/L/O -> Error, stay IDLE.
//    GOT_H: E -> GOT_E. GOT_E: L -> GOT_L1. GOT_L1: L -> GOT_L2.
//    GOT_L2: O -> IDLE, Match=1, WordCount+1 (held at 2^CNT_W-1; Match still pulses).
//    Any other legal symbol mid-word -> Error=1; next state GOT_H if symbol is H, else IDLE.
//  - Illegal code (101..111) with InValid: Error=1, state IDLE, LastSeg=7'b0111111 (dash).
//  - InValid=0: state, Progress, LastSeg and WordCount hold; In is ignored.
//  - LastSeg on accepted legal symbol: Blank 1111111, H 0001001, E 0000110, L 1000111, O 1000000.
//  - Timeout: timer clears on every InValid cycle and in IDLE; increments otherwise.
//    If state!=IDLE, InValid=0 and timer==TIMEOUT-1 -> Error=1, state IDLE, timer=0.
//    A symbol arriving on that same cycle wins: it is processed normally, no timeout.
//  - Match and Error never assert in the same cycle; both default to 0 every cycle.
// STRUCTURE
//  - Package hello_pkg: letter_t enum (BLANK,H,E,L,O; 3 bits), shared with the generator;
//    rx_state_t enum; SEG_* 7-bit localparams incl. SEG_DASH.
//  - Sub-module hello_seg_decode: combinational letter_t -> 7-bit active-low segment image
//    (illegal -> SEG_DASH); its output registered in hello_rx_checker.
//  - Top: one always_comb next-state/decision block, one always_ff for state, timer, outputs.
// TESTING
//  1 Reset low 2 cycles -> all outputs at reset values; then symbols 001,010,011,011,100 on
//    consecutive cycles -> Progress 1,2,3,4,0; Match=1 exactly one cycle; WordCount=1.
//  2 Symbols H,E,L,H,E,L,L,O -> Error pulse on 2nd H, state GOT_H, then Match; WordCount=1.
//  3 In=110 with InValid in GOT_E -> Error=1, Progress=0, LastSeg=7'b0111111.
//  4 H then InValid low TIMEOUT(16) cycles -> Error pulse cycle after 16th idle edge,
//    Progress=0; repeat with E on the 16th cycle -> no Error, Progress=2.
//  5 CNT_W=2: send 5 words -> WordCount 1,2,3,3,3; Match pulses all 5 times.
//  6 Reset low while Progress=3 -> next cycle Progress=0, no Error, WordCount=0.
//    Gapped InValid (1 of every 8 cycles, TIMEOUT=16) HELLO -> Match.

Source files
------------

// File: rtl/hello_pkg.sv
// Shared definitions for the HELLO letter-code link: letter codes, receiver
// states and the active-low gfedcba seven-segment images.
package hello_pkg;

    // Letter codes carried on the 3-bit link; 101..111 are illegal
    typedef enum logic [2:0] {
        BLANK = 3'b000,
        H     = 3'b001,
        E     = 3'b010,
        L     = 3'b011,
        O     = 3'b100
    } letter_t;

    // Receiver word-tracking states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_H  = 3'd1,
        GOT_E  = 3'd2,
        GOT_L1 = 3'd3,
        GOT_L2 = 3'd4
    } rx_state_t;

    // Active-low segment images, bit order gfedcba
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Number of letters matched so far in a given state
    function automatic logic [2:0] progress_of(input rx_state_t s);
        case (s)
            GOT_H:   progress_of = 3'd1;
            GOT_E:   progress_of = 3'd2;
            GOT_L1:  progress_of = 3'd3;
            GOT_L2:  progress_of = 3'd4;
            default: progress_of = 3'd0;
        endcase
    endfunction

    // Letter that advances the word from a given mid-word state
    function automatic letter_t expected_of(input rx_state_t s);
        case (s)
            GOT_H:   expected_of = E;
            GOT_E:   expected_of = L;
            GOT_L1:  expected_of = L;
            GOT_L2:  expected_of = O;
            default: expected_of = H;
        endcase
    endfunction

endpackage

// File: rtl/hello_seg_decode.sv
// Combinational letter-code to active-low seven-segment image; any code
// outside the letter set shows a dash.
module hello_seg_decode
    import hello_pkg::*;
(
    input  logic [2:0] i_code,
    output logic [6:0] o_seg
);

    logic [2:0] w_code;
    assign w_code = i_code;

    // Map each legal letter to its glyph, everything else to a dash
    always_comb begin
        o_seg = SEG_DASH;
        case (w_code)
            BLANK:   o_seg = SEG_BLANK;
            H:       o_seg = SEG_H;
            E:       o_seg = SEG_E;
            L:       o_seg = SEG_L;
            O:       o_seg = SEG_O;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/hello_rx_checker.sv
// Receive end of the HELLO letter stream: tracks progress through the word,
// pulses Match on each complete HELLO, pulses Error on mismatches, illegal
// codes and mid-word timeouts, and shows the last accepted letter.
module hello_rx_checker
    import hello_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [2:0]       In,
    input  logic             InValid,
    output logic             Match,
    output logic             Error,
    output logic [CNT_W-1:0] WordCount,
    output logic [2:0]       Progress,
    output logic [6:0]       LastSeg
);

    localparam int               TMR_W    = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    rx_state_t        r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_match;
    logic             r_error;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_progress;
    logic [6:0]       r_seg;

    rx_state_t        w_next_state;
    logic [TMR_W-1:0] w_next_timer;
    logic             w_match;
    logic             w_error;
    logic             w_legal;
    logic [6:0]       w_seg;

    hello_seg_decode u_seg_decode (
        .i_code (In),
        .o_seg  (w_seg)
    );

    assign w_legal = (In <= 3'd4);

    // Next-state, timer and pulse decisions for this cycle
    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        w_match      = 1'b0;
        w_error      = 1'b0;
        if (InValid) begin
            w_next_timer = '0;
            if (!w_legal) begin
                w_error      = 1'b1;
                w_next_state = IDLE;
            end else if (r_state == IDLE) begin
                // Blank between words is harmless; any other non-H is an error
                if (In == H) begin
                    w_next_state = GOT_H;
                end else if (In != BLANK) begin
                    w_error = 1'b1;
                end
            end else if (In == expected_of(r_state)) begin
                case (r_state)
                    GOT_H:   w_next_state = GOT_E;
                    GOT_E:   w_next_state = GOT_L1;
                    GOT_L1:  w_next_state = GOT_L2;
                    default: begin
                        w_next_state = IDLE;
                        w_match      = 1'b1;
                    end
                endcase
            end else begin
                // A stray H restarts the word rather than dropping it
                w_error      = 1'b1;
                w_next_state = (In == H) ? GOT_H : IDLE;
            end
        end else if (r_state != IDLE) begin
            if (r_timer == TMR_LAST) begin
                w_error      = 1'b1;
                w_next_state = IDLE;
                w_next_timer = '0;
            end else begin
                w_next_timer = r_timer + 1'b1;
            end
        end else begin
            w_next_timer = '0;
        end
    end

    // State, timer and all registered outputs
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_match    <= 1'b0;
            r_error    <= 1'b0;
            r_count    <= '0;
            r_progress <= 3'd0;
            r_seg      <= SEG_BLANK;
        end else begin
            r_state    <= w_next_state;
            r_timer    <= w_next_timer;
            r_match    <= w_match;
            r_error    <= w_error;
            r_progress <= progress_of(w_next_state);
            if (w_match && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
            if (InValid) begin
                r_seg <= w_seg;
            end
        end
    end

    assign Match     = r_match;
    assign Error     = r_error;
    assign WordCount = r_count;
    assign Progress  = r_progress;
    assign LastSeg   = r_seg;

endmodule
